// File: rtl/nios_usb_evt_ctrl_if.sv
// Avalon-MM slave bus bundle for the USB sideband event controller.
interface nios_usb_evt_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write, writedata,
    output readdata
  );
endinterface

// File: rtl/nios_usb_evt_ctrl.sv
// Event controller for the MAX3421E sideband pins (bit0=GPX, bit1=INT).
// Each pin is synchronised and glitch-filtered. Enabled rising and falling
// edges are latched into sticky EDGECAP bits, which drive a maskable level
// irq. A saturating counter counts the cycles that contain at least one
// captured edge.
module nios_usb_evt_ctrl #(
  parameter int NUM_IN      = 2,
  parameter int FILT_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  nios_usb_evt_ctrl_if.slave  bus,
  input  logic [NUM_IN-1:0]   in_port,
  output logic                irq
);

  localparam int FCW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  localparam logic [FCW-1:0]   FC_MAX  = FCW'(FILT_CYCLES - 1);
  localparam logic [CNT_W-1:0] EVT_MAX = '1;

  logic [NUM_IN-1:0] sync1, sync2, filt, filt_d;
  logic [NUM_IN-1:0] mask, edgecap, rise_en, fall_en;
  logic [NUM_IN-1:0] ev, w1c;
  logic [FCW-1:0]    fcnt [NUM_IN];
  logic [CNT_W-1:0]  evtcnt;
  logic              wr_en;
  logic [31:0]       rd_mux;

  assign wr_en = bus.chipselect & bus.write;
  assign ev    = (filt & ~filt_d & rise_en) | (~filt & filt_d & fall_en);
  assign w1c   = (wr_en && bus.address == 3'd2) ? bus.writedata[NUM_IN-1:0] : '0;

  // Two-flop synchroniser, then per-bit persistence filter and edge delay.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= '0;
      sync2  <= '0;
      filt   <= '0;
      filt_d <= '0;
      for (int unsigned i = 0; i < NUM_IN; i++) fcnt[i] <= '0;
    end else begin
      sync1  <= in_port;
      sync2  <= sync1;
      filt_d <= filt;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FC_MAX) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  // Software registers, sticky edge capture and saturating event counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask    <= '0;
      rise_en <= '0;
      fall_en <= '0;
      edgecap <= '0;
      evtcnt  <= '0;
    end else begin
      if (wr_en) begin
        case (bus.address)
          3'd1:    mask    <= bus.writedata[NUM_IN-1:0];
          3'd3:    rise_en <= bus.writedata[NUM_IN-1:0];
          3'd4:    fall_en <= bus.writedata[NUM_IN-1:0];
          default: ;
        endcase
      end
      // A new edge wins over a same-cycle write-one-to-clear.
      edgecap <= (edgecap & ~w1c) | ev;
      // A clear that coincides with an event leaves that event counted.
      if (wr_en && bus.address == 3'd5)
        evtcnt <= (|ev) ? CNT_W'(1) : '0;
      else if ((|ev) && evtcnt != EVT_MAX)
        evtcnt <= evtcnt + 1'b1;
    end
  end

  // Read multiplexer; unused bits and the reserved word read as zero.
  always_comb begin
    rd_mux = '0;
    case (bus.address)
      3'd0:    rd_mux[NUM_IN-1:0] = filt;
      3'd1:    rd_mux[NUM_IN-1:0] = mask;
      3'd2:    rd_mux[NUM_IN-1:0] = edgecap;
      3'd3:    rd_mux[NUM_IN-1:0] = rise_en;
      3'd4:    rd_mux[NUM_IN-1:0] = fall_en;
      3'd5:    rd_mux[CNT_W-1:0]  = evtcnt;
      3'd6:    rd_mux[0]          = irq;
      default: ;
    endcase
  end

  // Registered read data (every cycle, regardless of chipselect) and irq.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= '0;
      irq          <= 1'b0;
    end else begin
      bus.readdata <= rd_mux;
      irq          <= |(edgecap & mask);
    end
  end

endmodule
